// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Common data bus arbiter. Each functional unit hands one result
//               at a time into a one-entry holding buffer; every cycle up to
//               CDB_PORTS buffered results are granted and broadcast through a
//               registered CDB stage that feeds PRF writes, wakeup and ROB
//               completion.
//               Build option CDB_ARB_FIXED_PRIO_EN: when defined, fixed
//               priority (unit 0 highest) replaces round-robin and no rotating
//               pointer is kept.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_FU     = 4,
    parameter int CDB_PORTS  = 2,
    parameter int PHYS_WIDTH = 6,
    parameter int ROB_WIDTH  = 5
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  flush,
    input  logic [NUM_FU-1:0]                     fu_valid,
    output logic [NUM_FU-1:0]                     fu_ready,
    input  logic [NUM_FU-1:0][PHYS_WIDTH-1:0]     fu_paddr,
    input  logic [NUM_FU-1:0][31:0]               fu_data,
    input  logic [NUM_FU-1:0][ROB_WIDTH-1:0]      fu_rob_idx,
    output logic [CDB_PORTS-1:0]                  cdb_valid,
    output logic [CDB_PORTS-1:0][PHYS_WIDTH-1:0]  cdb_paddr,
    output logic [CDB_PORTS-1:0][31:0]            cdb_data,
    output logic [CDB_PORTS-1:0][ROB_WIDTH-1:0]   cdb_rob_idx,
    output logic [CDB_PORTS-1:0]                  pregf_we
);

    localparam int c_IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int c_PORT_W = (CDB_PORTS > 1) ? $clog2(CDB_PORTS) : 1;

    // Per-unit holding buffers
    logic [NUM_FU-1:0]                    r_buf_valid;
    logic [NUM_FU-1:0][PHYS_WIDTH-1:0]    r_buf_paddr;
    logic [NUM_FU-1:0][31:0]              r_buf_data;
    logic [NUM_FU-1:0][ROB_WIDTH-1:0]     r_buf_rob;

    // Registered CDB stage
    logic [CDB_PORTS-1:0]                 r_cdb_valid;
    logic [CDB_PORTS-1:0][PHYS_WIDTH-1:0] r_cdb_paddr;
    logic [CDB_PORTS-1:0][31:0]           r_cdb_data;
    logic [CDB_PORTS-1:0][ROB_WIDTH-1:0]  r_cdb_rob;

    // Arbitration results
    logic [NUM_FU-1:0]                    w_grant;
    logic [CDB_PORTS-1:0]                 w_port_vld;
    logic [CDB_PORTS-1:0][c_IDX_W-1:0]    w_port_src;
    logic [c_IDX_W-1:0]                   w_base;

`ifdef CDB_ARB_FIXED_PRIO_EN
    // Scan always starts at unit 0, so lower indices always win
    assign w_base = '0;
`else
    logic [c_IDX_W-1:0]                   r_rr_ptr;
    logic [c_IDX_W-1:0]                   w_last_idx;
    logic [c_IDX_W-1:0]                   w_rr_next;
    assign w_base = r_rr_ptr;
`endif

    // Scan buffers from the base index, handing the k-th occupied one to port k
    always_comb begin
        int                  v_cnt;
        logic [c_IDX_W-1:0]  v_idx;
        logic [c_PORT_W-1:0] v_pidx;
        w_grant    = '0;
        w_port_vld = '0;
        w_port_src = '0;
`ifndef CDB_ARB_FIXED_PRIO_EN
        w_last_idx = w_base;
`endif
        v_cnt      = 0;
        v_idx      = '0;
        v_pidx     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            v_idx = c_IDX_W'((int'(w_base) + k) % NUM_FU);
            if (r_buf_valid[v_idx] && (v_cnt < CDB_PORTS)) begin
                v_pidx             = c_PORT_W'(v_cnt);
                w_grant[v_idx]     = 1'b1;
                w_port_vld[v_pidx] = 1'b1;
                w_port_src[v_pidx] = v_idx;
`ifndef CDB_ARB_FIXED_PRIO_EN
                w_last_idx         = v_idx;
`endif
                v_cnt              = v_cnt + 1;
            end
        end
    end

    // A buffer is free when empty or when its entry leaves on this edge
    assign fu_ready = {NUM_FU{rst_n}} & (~r_buf_valid | w_grant);

    // Holding buffers: load on handshake, drain on grant, squash on flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= '0;
            r_buf_paddr <= '0;
            r_buf_data  <= '0;
            r_buf_rob   <= '0;
        end else if (flush) begin
            r_buf_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    r_buf_valid[i] <= 1'b1;
                    r_buf_paddr[i] <= fu_paddr[i];
                    r_buf_data[i]  <= fu_data[i];
                    r_buf_rob[i]   <= fu_rob_idx[i];
                end else if (w_grant[i]) begin
                    r_buf_valid[i] <= 1'b0;
                end
            end
        end
    end

    // CDB stage: granted entries broadcast for one cycle, idle ports read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cdb_valid <= '0;
            r_cdb_paddr <= '0;
            r_cdb_data  <= '0;
            r_cdb_rob   <= '0;
        end else if (flush) begin
            r_cdb_valid <= '0;
            r_cdb_paddr <= '0;
            r_cdb_data  <= '0;
            r_cdb_rob   <= '0;
        end else begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (w_port_vld[p]) begin
                    r_cdb_valid[p] <= 1'b1;
                    r_cdb_paddr[p] <= r_buf_paddr[w_port_src[p]];
                    r_cdb_data[p]  <= r_buf_data[w_port_src[p]];
                    r_cdb_rob[p]   <= r_buf_rob[w_port_src[p]];
                end else begin
                    r_cdb_valid[p] <= 1'b0;
                    r_cdb_paddr[p] <= '0;
                    r_cdb_data[p]  <= '0;
                    r_cdb_rob[p]   <= '0;
                end
            end
        end
    end

`ifndef CDB_ARB_FIXED_PRIO_EN
    assign w_rr_next = (w_last_idx == c_IDX_W'(NUM_FU - 1)) ? '0 : (w_last_idx + 1'b1);

    // Round-robin pointer moves one past the last winner; held across flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (!flush && (|w_grant)) begin
            r_rr_ptr <= w_rr_next;
        end
    end
`endif

    assign cdb_valid   = r_cdb_valid;
    assign cdb_paddr   = r_cdb_paddr;
    assign cdb_data    = r_cdb_data;
    assign cdb_rob_idx = r_cdb_rob;

    // x0 destinations complete in the ROB but never write the register file
    generate
        for (genvar p = 0; p < CDB_PORTS; p++) begin : g_pregf_we
            assign pregf_we[p] = r_cdb_valid[p] && (r_cdb_paddr[p] != '0);
        end
    endgenerate

endmodule
`default_nettype wire
